snake_head_ctrl: RTL and testbench

Sequential head-position controller for the snake playfield. It holds the head's 5-bit X/Y coordinates, divides the clock into movement steps, accepts direction requests with reversal filtering, and advances the head by one cell per step with modulo-32 wrap-around. Its registered coordinates feed the collision and body-tracking logic downstream. Those stages return a collision flag that halts the controller.

---
 rtl/snake_head_ctrl_pkg.sv | 25 ++
 rtl/snake_head_ctrl_if.sv | 25 ++
 rtl/snake_coord_step.sv | 19 +
 rtl/snake_head_ctrl.sv | 132 +++++++++++++
 tb/tb_snake_head_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/snake_head_ctrl_pkg.sv
// Shared types and helpers for the snake head controller: direction encoding,
// controller states and the default coordinate width.
package snake_pkg;

    localparam int COORD_W = 5;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // Opposite direction lives on the same axis with the sign bit flipped.
    function automatic logic [1:0] reverse(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_head_ctrl_if.sv
// Control/status bundle between the playfield logic and the head controller.
interface snake_head_ctrl_if #(
    parameter int COORD_W = snake_pkg::COORD_W
);
    logic               start;
    logic [1:0]         dir_req;
    logic               dir_req_valid;
    logic               collide;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic [1:0]         dir;
    logic               step_valid;
    logic               wrapped;
    logic               running;

    modport master (
        output start, dir_req, dir_req_valid, collide,
        input  head_x, head_y, dir, step_valid, wrapped, running
    );

    modport slave (
        input  start, dir_req, dir_req_valid, collide,
        output head_x, head_y, dir, step_valid, wrapped, running
    );
endinterface

// File: rtl/snake_coord_step.sv
// One-axis coordinate stepper: +1 or -1 modulo 2^COORD_W, with a flag for
// crossing the playfield edge.
module snake_coord_step #(
    parameter int COORD_W = snake_pkg::COORD_W
) (
    input  logic [COORD_W-1:0] coord,
    input  logic               dec,
    output logic [COORD_W-1:0] coord_next,
    output logic               wrap
);
    logic [COORD_W-1:0] addend;

    // Decrement is an add of all-ones; the carry-out simply falls off.
    always_comb begin
        addend     = dec ? {COORD_W{1'b1}} : COORD_W'(1);
        coord_next = coord + addend;
        wrap       = dec ? (coord == '0) : (coord == {COORD_W{1'b1}});
    end
endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head position controller: IDLE/RUN/HALT FSM, movement-step divider,
// reversal-filtered direction requests and per-axis wrap-around stepping.
module snake_head_ctrl
    import snake_pkg::*;
#(
    parameter int                 COORD_W   = snake_pkg::COORD_W,
    parameter int                 TICK_DIV  = 4,
    parameter logic [COORD_W-1:0] START_X   = COORD_W'(16),
    parameter logic [COORD_W-1:0] START_Y   = COORD_W'(16),
    parameter logic [1:0]         START_DIR = 2'b00
) (
    input logic               clk,
    input logic               rst,
    snake_head_ctrl_if.slave  bus
);
    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] head_x_q, head_x_d;
    logic [COORD_W-1:0] head_y_q, head_y_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         pend_dir_q, pend_dir_d;
    logic               step_valid_q, step_valid_d;
    logic               wrapped_q, wrapped_d;
    logic               running;
    logic               step_fire;
    logic [COORD_W-1:0] x_next, y_next;
    logic               x_wrap, y_wrap;

    // Both axes are evaluated every cycle; pend_dir[0] picks which one commits.
    snake_coord_step #(.COORD_W(COORD_W)) u_step_x (
        .coord      (head_x_q),
        .dec        (pend_dir_q[1]),
        .coord_next (x_next),
        .wrap       (x_wrap)
    );

    snake_coord_step #(.COORD_W(COORD_W)) u_step_y (
        .coord      (head_y_q),
        .dec        (pend_dir_q[1]),
        .coord_next (y_next),
        .wrap       (y_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && bus.collide) begin
            state_d = ST_HALT;
        end
    end

    always_comb begin
        running = (state_q == ST_RUN);
    end

    // Start and collide both pre-empt a step that would otherwise fire this cycle.
    always_comb begin
        step_fire    = (state_q == ST_RUN) && (cnt_q == CNT_LAST)
                       && !bus.collide && !bus.start;
        cnt_d        = cnt_q;
        head_x_d     = head_x_q;
        head_y_d     = head_y_q;
        dir_d        = dir_q;
        pend_dir_d   = pend_dir_q;
        step_valid_d = 1'b0;
        wrapped_d    = 1'b0;
        if (bus.start) begin
            cnt_d      = '0;
            head_x_d   = START_X;
            head_y_d   = START_Y;
            dir_d      = START_DIR;
            pend_dir_d = START_DIR;
        end else begin
            if (bus.dir_req_valid && (bus.dir_req != reverse(dir_q))) begin
                pend_dir_d = bus.dir_req;
            end
            if (state_q == ST_RUN && !bus.collide) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            if (step_fire) begin
                dir_d        = pend_dir_q;
                step_valid_d = 1'b1;
                if (pend_dir_q[0]) begin
                    head_y_d  = y_next;
                    wrapped_d = y_wrap;
                end else begin
                    head_x_d  = x_next;
                    wrapped_d = x_wrap;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            head_x_q     <= START_X;
            head_y_q     <= START_Y;
            dir_q        <= START_DIR;
            pend_dir_q   <= START_DIR;
            step_valid_q <= 1'b0;
            wrapped_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            head_x_q     <= head_x_d;
            head_y_q     <= head_y_d;
            dir_q        <= dir_d;
            pend_dir_q   <= pend_dir_d;
            step_valid_q <= step_valid_d;
            wrapped_q    <= wrapped_d;
        end
    end

    assign bus.head_x     = head_x_q;
    assign bus.head_y     = head_y_q;
    assign bus.dir        = dir_q;
    assign bus.step_valid = step_valid_q;
    assign bus.wrapped    = wrapped_q;
    assign bus.running    = running;
endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench for snake_head_ctrl with TICK_DIV=4 and start position (16,16).
module tb_snake_head_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    snake_head_ctrl_if bus ();

    snake_head_ctrl #(
        .COORD_W   (5),
        .TICK_DIV  (4),
        .START_X   (5'd16),
        .START_Y   (5'd16),
        .START_DIR (2'b00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int x, input int y, input int d,
                           input int sv, input int wr, input int run);
        chk(tag, "head_x",     32'(bus.head_x),     32'(x));
        chk(tag, "head_y",     32'(bus.head_y),     32'(y));
        chk(tag, "dir",        32'(bus.dir),        32'(d));
        chk(tag, "step_valid", 32'(bus.step_valid), 32'(sv));
        chk(tag, "wrapped",    32'(bus.wrapped),    32'(wr));
        chk(tag, "running",    32'(bus.running),    32'(run));
    endtask

    task automatic req(input logic [1:0] d);
        bus.dir_req       = d;
        bus.dir_req_valid = 1'b1;
        tick(1);
        bus.dir_req_valid = 1'b0;
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst               = 1'b0;
        bus.start         = 1'b0;
        bus.dir_req       = 2'b00;
        bus.dir_req_valid = 1'b0;
        bus.collide       = 1'b0;
        #1 rst = 1'b1;
        tick(2);
        chk_all("reset", 16, 16, 0, 0, 0, 0);
        rst = 1'b0;
        tick(3);
        chk_all("idle_hold", 16, 16, 0, 0, 0, 0);

        // First start: step after 4 edges, then every 4.
        bus.start = 1'b1; tick(1); bus.start = 1'b0;
        chk_all("start", 16, 16, 0, 0, 0, 1);
        tick(3);
        chk("pre_step1", "step_valid", 32'(bus.step_valid), 0);
        tick(1);
        chk_all("step1", 17, 16, 0, 1, 0, 1);
        tick(1);
        chk("post_step1", "step_valid", 32'(bus.step_valid), 0);
        tick(3);
        chk_all("step2", 18, 16, 0, 1, 0, 1);

        // Walk right to the edge and across it.
        repeat (13) tick(4);
        chk_all("x31", 31, 16, 0, 1, 0, 1);
        tick(4);
        chk_all("wrap_right", 0, 16, 0, 1, 1, 1);
        tick(1);
        chk("wrap_pulse", "wrapped", 32'(bus.wrapped), 0);

        // Turn up and walk across the top edge.
        req(2'b11); tick(2);
        chk_all("turn_up", 0, 15, 3, 1, 0, 1);
        repeat (15) tick(4);
        chk_all("y0", 0, 0, 3, 1, 0, 1);
        tick(4);
        chk_all("wrap_up", 0, 31, 3, 1, 1, 1);

        // Reversal filtering: right, then left(dropped)+down, then lone up(dropped).
        req(2'b00); tick(3);
        chk_all("turn_right", 1, 31, 0, 1, 0, 1);
        req(2'b10); req(2'b01); tick(2);
        chk_all("left_then_down", 1, 0, 1, 1, 1, 1);
        req(2'b11); tick(3);
        chk_all("reverse_dropped", 1, 1, 1, 1, 0, 1);

        // Requests sampled on the step edge only affect the following step.
        tick(3); req(2'b00);
        chk_all("edge_req_right", 1, 2, 1, 1, 0, 1);
        tick(4);
        chk_all("after_edge_right", 2, 2, 0, 1, 0, 1);
        tick(3); req(2'b11);
        chk_all("edge_req_up", 3, 2, 0, 1, 0, 1);
        tick(4);
        chk_all("after_edge_up", 3, 1, 3, 1, 0, 1);

        // Collide coinciding with cnt==3 blocks the step and halts.
        tick(3);
        bus.collide = 1'b1; tick(1); bus.collide = 1'b0;
        chk_all("collide", 3, 1, 3, 0, 0, 0);
        bus.collide = 1'b1; tick(1); bus.collide = 1'b0;
        tick(3);
        chk_all("halt_hold", 3, 1, 3, 0, 0, 0);

        bus.start = 1'b1; tick(1); bus.start = 1'b0;
        chk_all("restart", 16, 16, 0, 0, 0, 1);
        tick(3);
        chk("restart_pre", "step_valid", 32'(bus.step_valid), 0);
        tick(1);
        chk_all("restart_step", 17, 16, 0, 1, 0, 1);

        // start beats a same-cycle dir request, and beats collide.
        bus.start = 1'b1; bus.dir_req = 2'b01; bus.dir_req_valid = 1'b1;
        tick(1);
        bus.start = 1'b0; bus.dir_req_valid = 1'b0;
        chk_all("start_vs_req", 16, 16, 0, 0, 0, 1);
        tick(4);
        chk_all("start_vs_req_step", 17, 16, 0, 1, 0, 1);
        bus.start = 1'b1; bus.collide = 1'b1;
        tick(1);
        bus.start = 1'b0; bus.collide = 1'b0;
        chk_all("start_vs_collide", 16, 16, 0, 0, 0, 1);
        tick(4);
        chk_all("start_vs_collide_step", 17, 16, 0, 1, 0, 1);

        // Async reset two cycles into a step period.
        req(2'b01); tick(3);
        chk_all("turn_down", 17, 17, 1, 1, 0, 1);
        tick(2);
        rst = 1'b1;
        #2;
        chk_all("async_rst", 16, 16, 0, 0, 0, 0);
        tick(1);
        rst = 1'b0;
        repeat (8) begin
            tick(1);
            chk("post_rst", "step_valid", 32'(bus.step_valid), 0);
        end
        chk_all("post_rst_idle", 16, 16, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
